// File: rtl/riscv_pkg.sv
// Purpose : RV32I decode types shared by the decode stage and the field extractor.
// Contents: fmt_e instruction-format enum, base opcode constants, decoded-field
//           record and a helper mapping a major opcode to its format.
package riscv_pkg;

  typedef enum logic [2:0] {
    FmtR    = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtNone = 3'd6
  } fmt_e;

  localparam logic [6:0] OpRInt    = 7'b0110011;
  localparam logic [6:0] OpIInt    = 7'b0010011;
  localparam logic [6:0] OpILoad   = 7'b0000011;
  localparam logic [6:0] OpIJump   = 7'b1100111;  // jalr
  localparam logic [6:0] OpFence   = 7'b0001111;
  localparam logic [6:0] OpSystem  = 7'b1110011;
  localparam logic [6:0] OpSStore  = 7'b0100011;
  localparam logic [6:0] OpSBranch = 7'b1100011;
  localparam logic [6:0] OpUImm    = 7'b0110111;  // lui
  localparam logic [6:0] OpUPc     = 7'b0010111;  // auipc
  localparam logic [6:0] OpUJump   = 7'b1101111;  // jal

  localparam logic [6:0] Funct7Base = 7'b0000000;
  localparam logic [6:0] Funct7Alt  = 7'b0100000;

  typedef struct packed {
    fmt_e       fmt;
    logic       illegal;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
  } fields_t;

  localparam fields_t FieldsNone = '{
    fmt: FmtNone, illegal: 1'b0, opcode: 7'd0, funct7: 7'd0,
    funct3: 3'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0
  };

  // Format implied by the major opcode alone; FmtNone for unlisted opcodes.
  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_of = FmtNone;
    case (op)
      OpRInt:                                       fmt_of = FmtR;
      OpIInt, OpILoad, OpIJump, OpFence, OpSystem:  fmt_of = FmtI;
      OpSStore:                                     fmt_of = FmtS;
      OpSBranch:                                    fmt_of = FmtB;
      OpUImm, OpUPc:                                fmt_of = FmtU;
      OpUJump:                                      fmt_of = FmtJ;
      default:                                      fmt_of = FmtNone;
    endcase
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Purpose : combinational RV32I field and immediate extraction.
// Latency : 0 cycles (pure combinational).
// Backpr. : none; the caller registers the result.
// Ports   : i_instr (raw word) -> o_fields (format, illegal flag, fields zeroed
//           where the format does not use them), o_immediate (sign-extended, XLEN).
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output fields_t         o_fields,
  output logic [XLEN-1:0] o_immediate
);

  fmt_e        fmt;
  logic [31:0] imm32;

  always_comb begin
    fmt = fmt_of(i_instr[6:0]);
    // Compressed/invalid length encodings are not decodable here.
    if (i_instr[1:0] != 2'b11) fmt = FmtNone;
    // Only the base and alternate (sub/sra) funct7 encodings are accepted for R-type.
    if (fmt == FmtR && i_instr[31:25] != Funct7Base && i_instr[31:25] != Funct7Alt) begin
      fmt = FmtNone;
    end
  end

  always_comb begin
    o_fields         = FieldsNone;
    imm32            = 32'd0;
    o_fields.fmt     = fmt;
    o_fields.illegal = (fmt == FmtNone);
    if (fmt != FmtNone) o_fields.opcode = i_instr[6:0];
    case (fmt)
      FmtR: begin
        o_fields.funct7 = i_instr[31:25];
        o_fields.funct3 = i_instr[14:12];
        o_fields.rs1    = i_instr[19:15];
        o_fields.rs2    = i_instr[24:20];
        o_fields.rd     = i_instr[11:7];
      end
      FmtI: begin
        o_fields.funct3 = i_instr[14:12];
        o_fields.rs1    = i_instr[19:15];
        o_fields.rd     = i_instr[11:7];
        imm32           = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      FmtS: begin
        o_fields.funct3 = i_instr[14:12];
        o_fields.rs1    = i_instr[19:15];
        o_fields.rs2    = i_instr[24:20];
        imm32           = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      end
      FmtB: begin
        o_fields.funct3 = i_instr[14:12];
        o_fields.rs1    = i_instr[19:15];
        o_fields.rs2    = i_instr[24:20];
        imm32           = {{20{i_instr[31]}}, i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
      end
      FmtU: begin
        o_fields.rd     = i_instr[11:7];
        imm32           = {i_instr[31:12], 12'd0};
      end
      FmtJ: begin
        o_fields.rd     = i_instr[11:7];
        imm32           = {{12{i_instr[31]}}, i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Signed size cast sign-extends the 32-bit immediate to the datapath width.
  assign o_immediate = XLEN'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// Purpose : RV32I decode pipeline stage with valid/ready handshake on both sides.
// Latency : 1 cycle from input accept to o_valid.
// Backpr. : SKID=1 two-entry skid, o_ready registered and low only while the
//           skid entry is full; SKID=0 single register, ready when empty or draining.
// Ports   : clk/rstn, i_flush; fetch side i_valid/o_ready/i_instr/i_pc; execute side
//           o_valid/i_ready and the decoded record (pc, fields, immediate, fmt, illegal).
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [6:0]      o_opcode,
  output logic [6:0]      o_funct7,
  output logic [2:0]      o_funct3,
  output logic [4:0]      o_rs1_raddr,
  output logic [4:0]      o_rs2_raddr,
  output logic [4:0]      o_rd_waddr,
  output logic [XLEN-1:0] o_immediate,
  output fmt_e            o_fmt,
  output logic            o_illegal
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,  // nothing held
    StOne   = 2'd1,  // output register full
    StTwo   = 2'd2   // output register and skid entry full
  } state_e;

  typedef struct packed {
    fields_t         f;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } rec_t;

  localparam rec_t RecNone = '{f: FieldsNone, imm: '0, pc: '0};

  state_e          state_q, state_d;
  rec_t            out_q, out_d;
  rec_t            skid_q, skid_d;
  logic            ready_q, ready_d;
  fields_t         in_fields;
  logic [XLEN-1:0] in_imm;
  rec_t            in_rec;
  logic            accept;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_instr     (i_instr),
    .o_fields    (in_fields),
    .o_immediate (in_imm)
  );

  assign in_rec = '{f: in_fields, imm: in_imm, pc: i_pc};
  assign accept = i_valid && o_ready;

  // ready_q is zero in reset and rises on the first edge afterwards. With SKID=0
  // it only gates the combinational ready so o_ready stays low during reset.
  assign o_ready = (SKID != 0) ? ready_q
                               : (ready_q && (state_q == StEmpty || i_ready));

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          out_d   = in_rec;
        end
      end
      StOne: begin
        // With SKID=0, accept in StOne implies i_ready, so StTwo is unreachable.
        if (accept && !i_ready) begin
          state_d = StTwo;
          skid_d  = in_rec;
        end else if (accept) begin
          out_d   = in_rec;
        end else if (i_ready) begin
          state_d = StEmpty;
        end
      end
      StTwo: begin
        if (i_ready) begin
          state_d = StOne;
          out_d   = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flush wins over any simultaneous accept or drain; stale data is left in
    // the registers but nothing is marked valid.
    if (i_flush) state_d = StEmpty;
  end

  assign ready_d = (SKID != 0) ? (state_d != StTwo) : 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StEmpty;
      out_q   <= RecNone;
      skid_q  <= RecNone;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

  assign o_valid     = (state_q != StEmpty);
  assign o_pc        = out_q.pc;
  assign o_opcode    = out_q.f.opcode;
  assign o_funct7    = out_q.f.funct7;
  assign o_funct3    = out_q.f.funct3;
  assign o_rs1_raddr = out_q.f.rs1;
  assign o_rs2_raddr = out_q.f.rs2;
  assign o_rd_waddr  = out_q.f.rd;
  assign o_immediate = out_q.imm;
  assign o_fmt       = out_q.f.fmt;
  assign o_illegal   = out_q.f.illegal;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  import riscv_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rstn, i_flush, i_valid, o_ready, o_valid, i_ready, o_illegal;
  logic [31:0]     i_instr;
  logic [XLEN-1:0] i_pc, o_pc, o_immediate;
  logic [6:0]      o_opcode, o_funct7;
  logic [2:0]      o_funct3;
  logic [4:0]      o_rs1_raddr, o_rs2_raddr, o_rd_waddr;
  fmt_e            o_fmt;

  decode_stage #(.XLEN(XLEN), .SKID(1)) dut (
    .clk(clk), .rstn(rstn), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_instr(i_instr), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready), .o_pc(o_pc),
    .o_opcode(o_opcode), .o_funct7(o_funct7), .o_funct3(o_funct3),
    .o_rs1_raddr(o_rs1_raddr), .o_rs2_raddr(o_rs2_raddr), .o_rd_waddr(o_rd_waddr),
    .o_immediate(o_immediate), .o_fmt(o_fmt), .o_illegal(o_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    fmt_e        fmt;
    logic        ill;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [31:0] pc;
  } exp_t;

  int   n_chk = 0, n_pass = 0;
  exp_t sbq[$];   // expected contents of the stage, oldest first
  exp_t tbl[$];
  int   emitted = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic exp_t mk(input logic [31:0] ins, input fmt_e f, input logic ill,
                              input logic [6:0] opc, input logic [6:0] f7,
                              input logic [2:0] f3, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [4:0] rd,
                              input logic [31:0] imm);
    exp_t r;
    r.instr = ins; r.fmt = f; r.ill = ill; r.opc = opc; r.f7 = f7; r.f3 = f3;
    r.rs1 = rs1; r.rs2 = rs2; r.rd = rd; r.imm = imm; r.pc = 32'd0;
    return r;
  endfunction

  // Reference decoder: format from the opcode list, then each field present or
  // absent per format, immediates built with signed arithmetic.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    exp_t r;
    fmt_e f;
    int   s;
    s = $signed(ins);
    case (ins[6:0])
      7'h33:                         f = (ins[31:25] == 7'h00 || ins[31:25] == 7'h20) ? FmtR : FmtNone;
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: f = FmtI;
      7'h23:                         f = FmtS;
      7'h63:                         f = FmtB;
      7'h37, 7'h17:                  f = FmtU;
      7'h6F:                         f = FmtJ;
      default:                       f = FmtNone;
    endcase
    if (ins[1:0] != 2'b11) f = FmtNone;
    r = mk(ins, f, f == FmtNone, 7'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    r.pc = pc;
    if (f != FmtNone) r.opc = ins[6:0];
    if (f == FmtR) r.f7 = ins[31:25];
    if (f inside {FmtR, FmtI, FmtS, FmtB}) begin r.f3 = ins[14:12]; r.rs1 = ins[19:15]; end
    if (f inside {FmtR, FmtS, FmtB}) r.rs2 = ins[24:20];
    if (f inside {FmtR, FmtI, FmtU, FmtJ}) r.rd = ins[11:7];
    case (f)
      FmtI: r.imm = s >>> 20;
      FmtS: r.imm = (s >>> 25) * 32 + int'(ins[11:7]);
      FmtB: r.imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                    + int'(ins[11:8]) * 2;
      FmtU: r.imm = ins & 32'hFFFF_F000;
      FmtJ: r.imm = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                    + int'(ins[30:21]) * 2;
      default: r.imm = 32'd0;
    endcase
    return r;
  endfunction

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, "_fmt"}, 64'(o_fmt), 64'(e.fmt));
    chk({tag, "_illegal"}, 64'(o_illegal), 64'(e.ill));
    chk({tag, "_fields"}, 64'({o_opcode, o_funct7, o_funct3, o_rs1_raddr, o_rs2_raddr, o_rd_waddr}),
        64'({e.opc, e.f7, e.f3, e.rs1, e.rs2, e.rd}));
    chk({tag, "_imm"}, 64'(o_immediate), 64'(e.imm));
    chk({tag, "_pc"}, 64'(o_pc), 64'(e.pc));
  endtask

  task automatic check_flow(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'(sbq.size() > 0));
    chk({tag, "_ready"}, 64'(o_ready), 64'(sbq.size() < 2));
    if (sbq.size() > 0) check_out(tag, sbq[0]);
  endtask

  // Called just after a falling edge: drive, advance the model, cross one
  // rising edge and check on the next falling edge.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [31:0] pc, input logic rdy, input logic fl);
    bit acc;
    i_valid = v; i_instr = ins; i_pc = pc; i_ready = rdy; i_flush = fl;
    if (fl) begin
      sbq.delete();
    end else begin
      acc = v && (sbq.size() < 2);
      if (sbq.size() > 0 && rdy) begin
        void'(sbq.pop_front());
        emitted++;
      end
      if (acc) sbq.push_back(ref_dec(ins, pc));
    end
    @(posedge clk);
    @(negedge clk);
    check_flow(tag);
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 13))
      0:  w[6:0] = 7'h33;
      1:  w[6:0] = 7'h13;
      2:  w[6:0] = 7'h03;
      3:  w[6:0] = 7'h67;
      4:  w[6:0] = 7'h0F;
      5:  w[6:0] = 7'h73;
      6:  w[6:0] = 7'h23;
      7:  w[6:0] = 7'h63;
      8:  w[6:0] = 7'h37;
      9:  w[6:0] = 7'h17;
      10: w[6:0] = 7'h6F;
      11: begin w[6:0] = 7'h33; w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, cyc, em0;
    logic [31:0] seq [10];

    tbl.push_back(mk(32'hFFF10093, FmtI,    0, 7'h13, 7'h00, 3'd0, 5'd2, 5'd0,  5'd1, 32'hFFFFFFFF));
    tbl.push_back(mk(32'hFE000EE3, FmtB,    0, 7'h63, 7'h00, 3'd0, 5'd0, 5'd0,  5'd0, 32'hFFFFFFFC));
    tbl.push_back(mk(32'h123452B7, FmtU,    0, 7'h37, 7'h00, 3'd0, 5'd0, 5'd0,  5'd5, 32'h12345000));
    tbl.push_back(mk(32'h00000000, FmtNone, 1, 7'h00, 7'h00, 3'd0, 5'd0, 5'd0,  5'd0, 32'h0));
    tbl.push_back(mk(32'h40000033, FmtR,    0, 7'h33, 7'h20, 3'd0, 5'd0, 5'd0,  5'd0, 32'h0));
    tbl.push_back(mk(32'h02000033, FmtNone, 1, 7'h00, 7'h00, 3'd0, 5'd0, 5'd0,  5'd0, 32'h0));
    tbl.push_back(mk(32'h00A12223, FmtS,    0, 7'h23, 7'h00, 3'd2, 5'd2, 5'd10, 5'd0, 32'h4));
    tbl.push_back(mk(32'h008000EF, FmtJ,    0, 7'h6F, 7'h00, 3'd0, 5'd0, 5'd0,  5'd1, 32'h8));
    tbl.push_back(mk(32'h00000073, FmtI,    0, 7'h73, 7'h00, 3'd0, 5'd0, 5'd0,  5'd0, 32'h0));
    tbl.push_back(mk(32'h0000000B, FmtNone, 1, 7'h00, 7'h00, 3'd0, 5'd0, 5'd0,  5'd0, 32'h0));
    tbl.push_back(mk(32'h00000001, FmtNone, 1, 7'h00, 7'h00, 3'd0, 5'd0, 5'd0,  5'd0, 32'h0));
    tbl.push_back(mk(32'hFE010113, FmtI,    0, 7'h13, 7'h00, 3'd0, 5'd2, 5'd0,  5'd2, 32'hFFFFFFE0));

    // Reset: make a real falling edge on rstn, then check outputs held in reset.
    rstn = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_instr = '0; i_pc = '0;
    #2 rstn = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(o_valid), 64'(0));
    chk("rst_ready", 64'(o_ready), 64'(0));
    chk("rst_fmt", 64'(o_fmt), 64'(FmtNone));
    chk("rst_data", 64'({o_pc, o_immediate}), 64'(0));
    chk("rst_fields", 64'({o_opcode, o_funct7, o_funct3, o_rs1_raddr, o_rs2_raddr, o_rd_waddr, o_illegal}), 64'(0));
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_flow("post_rst");

    // Directed decode vectors, one at a time with execute always ready.
    for (int i = 0; i < tbl.size(); i++) begin
      tbl[i].pc = 32'h1000 + 32'(i) * 4;
      step("tab_flow", 1'b1, tbl[i].instr, tbl[i].pc, 1'b1, 1'b0);
      check_out($sformatf("tab%0d", i), tbl[i]);
      step("tab_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end

    // Ten back-to-back with i_ready toggling 1,0,1,0...
    for (int i = 0; i < 10; i++) seq[i] = tbl[i % tbl.size()].instr ^ (32'(i) << 7);
    em0 = emitted; k = 0; cyc = 0;
    while (k < 10 && cyc < 100) begin
      if (sbq.size() < 2) begin
        step("seq", 1'b1, seq[k], 32'h2000 + 32'(k) * 4, (cyc % 2) == 0, 1'b0);
        k++;
      end else begin
        step("seq", 1'b1, seq[k], 32'h2000 + 32'(k) * 4, (cyc % 2) == 0, 1'b0);
      end
      cyc++;
    end
    for (int i = 0; i < 6 && sbq.size() > 0; i++) step("seq_drain", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("seq_emitted", 64'(emitted - em0), 64'(10));

    // Continuous valid/ready: no bubbles expected after the first.
    for (int i = 0; i < 8; i++) step("stream", 1'b1, rnd_instr(), 32'h3000 + 32'(i) * 4, 1'b1, 1'b0);
    step("stream_end", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Flush while full with another instruction presented.
    step("fill1", 1'b1, 32'hFFF10093, 32'h4000, 1'b0, 1'b0);
    step("fill2", 1'b1, 32'h123452B7, 32'h4004, 1'b0, 1'b0);
    step("flush", 1'b1, 32'hFE000EE3, 32'h4008, 1'b1, 1'b1);
    chk("flush_valid", 64'(o_valid), 64'(0));
    chk("flush_ready", 64'(o_ready), 64'(1));
    step("after_flush", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset mid-stream while full.
    step("rfill1", 1'b1, 32'h00A12223, 32'h5000, 1'b0, 1'b0);
    step("rfill2", 1'b1, 32'h008000EF, 32'h5004, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'(0));
    chk("midrst_ready", 64'(o_ready), 64'(0));
    chk("midrst_fmt", 64'(o_fmt), 64'(FmtNone));
    sbq.delete();
    i_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_flow("after_midrst");

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      step("rnd", $urandom_range(0, 9) < 7, rnd_instr(), {$urandom, 2'b00} , $urandom_range(0, 9) < 6,
           $urandom_range(0, 99) < 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter XLEN, default 32, meaning data/immediate width; legal values 32 and 64.
REQ-002 Parameter SKID, default 1, meaning 1 = two-entry skid buffer (full throughput), 0 = single register (ready only when output empty or accepted).
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 i_flush  input  1  discard all held instructions.
REQ-006 i_valid  input  1  fetch presents instruction.
REQ-007 o_ready  output  1  stage accepts instruction this cycle.
REQ-008 i_instr  input  32  raw instruction word.
REQ-009 i_pc  input  XLEN  instruction address.
REQ-010 o_valid  output  1  decoded instruction available.
REQ-011 i_ready  input  1  execute accepts decoded instruction.
REQ-012 o_pc  output  XLEN  address of decoded instruction.
REQ-013 o_opcode/o_funct7/o_funct3  output  7/7/3  instruction fields, zero where unused by format.
REQ-014 o_rs1_raddr/o_rs2_raddr/o_rd_waddr  output  5/5/5  register addresses, zero where unused.
REQ-015 o_immediate  output  XLEN  sign-extended immediate.
REQ-016 o_fmt  output  fmt_e  instruction format.
REQ-017 o_illegal  output  1  instruction not decodable.

Function
REQ-018 Transfer in on i_valid&&o_ready; out on o_valid&&i_ready; latency exactly 1 cycle from input accept to o_valid.
REQ-019 SKID=1: o_ready registered, deasserted only when skid entry occupied; no bubble under continuous valid/ready.
REQ-020 SKID=1 states EMPTY, ONE (output reg full), TWO (output + skid full); EMPTY->ONE on accept; ONE->TWO on accept with !i_ready; TWO->ONE on i_ready (skid moves to output); ONE->EMPTY on i_ready without accept.
REQ-021 Output fields SHALL remain stable while o_valid&&!i_ready.
REQ-022 Decode: R (OpRInt), I (OpIInt, OpILoad, OpIJump, OpFence, OpSystem), S (OpSStore), B (OpSBranch), U (OpUImm, OpUPc), J (OpUJump); fields per RV32I base encoding.
REQ-023 Immediates: I = sext(instr[31:20]); S = sext({instr[31:25],instr[11:7]}); B = sext({instr[31],instr[7],instr[30:25],instr[11:8],0}); U = sext({instr[31:12],12'b0}) to XLEN; J = sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
REQ-024 o_illegal=1 when instr[1:0]!=2'b11, opcode unlisted, or OpRInt with funct7 not 0000000/0100000; then o_fmt=FmtNone, all fields and immediate zero, o_pc valid.
REQ-025 i_flush: next cycle o_valid=0, all entries empty, o_ready=1; an input presented with i_flush is dropped; flush has priority over simultaneous accept/drain.

Reset
REQ-026 While rstn=0: o_valid=0, state EMPTY, o_ready=0; all data outputs 0, o_fmt=FmtNone.
REQ-027 o_ready=1 from first clock edge after rstn deasserts; reset mid-transfer drops all held instructions.

Structure
REQ-028 fmt_e (FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ, FmtNone) and opcode constants incl. new OpFence, OpSystem belong in riscv_pkg.
REQ-029 Combinational field/immediate extraction in sub-module imm_gen (parametrised XLEN); decode_stage holds handshake and registers.

Verification
REQ-030 0xFFF10093 (addi x1,x2,-1) -> o_fmt=FmtI, rs1=2, rd=1, immediate=0xFFFFFFFF, o_illegal=0, one cycle later.
REQ-031 0xFE000EE3 (beq x0,x0,-4) -> FmtB, immediate=0xFFFFFFFC, rd=0; 0x123452B7 (lui x5) -> FmtU, rd=5, immediate=0x12345000 (XLEN=64: 0x0000000012345000).
REQ-032 0x00000000 and 0x40000033 / 0x02000033 funct7 check -> first and third o_illegal=1, FmtNone, fields zero; second legal (sub).
REQ-033 10 back-to-back instructions with i_ready toggling 1,0,1,0 -> in-order, none lost/duplicated, SKID=1 zero bubbles when i_ready=1, outputs stable while stalled.
REQ-034 i_flush asserted in TWO state with i_valid=1 -> next cycle o_valid=0, o_ready=1, none of the three instructions emerge; rstn pulsed mid-stream -> same empty result.
